// File: rtl/down_counter_timer.sv
// -----------------------------------------------------------------------------
// down_counter_timer
//
// A loadable timer that counts down. It loads a start value, decrements on
// enabled clock ticks (optionally prescaled) and pulses `done` for one cycle
// when it expires. It supports one-shot and auto-reload modes and can be
// aborted. Control FSMs use it as a timeout or interval generator.
//
// Parameters
//   WIDTH     bit width of load_value and count
//   PRESCALE  enabled cycles per decrement (>= 1)
//
// Ports
//   clock        rising-edge clock for all state
//   reset        asynchronous active-low reset
//   start        load load_value and begin counting (restart when running)
//   load_value   initial / reload count, sampled only while start=1
//   enable       tick qualifier; prescaler and count advance only when 1
//   auto_reload  1: reload on expiry and keep running, 0: one-shot
//   abort        return to IDLE without producing done
//   count        remaining count (registered)
//   busy         1 while in RUN (registered)
//   done         one-cycle expiry pulse (registered)
//
// Priority at every edge: abort > start > decrement.
// -----------------------------------------------------------------------------
module down_counter_timer #(
   parameter int WIDTH    = 8,
   parameter int PRESCALE = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   input  logic             auto_reload,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
);

   // The prescaler needs at least one bit even when PRESCALE=1. In that case
   // it stays at 0, and every enabled cycle is a decrement tick.
   localparam int             PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] count_reg;
   logic [WIDTH-1:0] reload_reg;
   logic [PW-1:0]    prescale_reg;
   logic             busy_reg;
   logic             done_reg;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         count_reg    <= '0;
         reload_reg   <= '0;
         prescale_reg <= '0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         // done is a pulse. Only an expiry or a zero-length start raises it.
         done_reg <= 1'b0;

         if (abort) begin
            state        <= IDLE;
            busy_reg     <= 1'b0;
            count_reg    <= '0;
            prescale_reg <= '0;
         end else if (start) begin
            prescale_reg <= '0;
            if (load_value != '0) begin
               count_reg  <= load_value;
               reload_reg <= load_value;
               state      <= RUN;
               busy_reg   <= 1'b1;
            end else begin
               // A zero-length timer expires at once and never enters RUN.
               done_reg  <= 1'b1;
               count_reg <= '0;
               state     <= IDLE;
               busy_reg  <= 1'b0;
            end
         end else if (state == RUN && enable) begin
            if (prescale_reg != PS_LAST) begin
               prescale_reg <= prescale_reg + 1'b1;
            end else begin
               prescale_reg <= '0;
               if (count_reg > WIDTH'(1)) begin
                  count_reg <= count_reg - WIDTH'(1);
               end else if (count_reg == WIDTH'(1)) begin
                  // Expiry. In auto-reload mode the reload happens on this
                  // same edge, so there is no gap between periods.
                  done_reg <= 1'b1;
                  if (auto_reload) begin
                     count_reg <= reload_reg;
                  end else begin
                     count_reg <= '0;
                     state     <= IDLE;
                     busy_reg  <= 1'b0;
                  end
               end
               // count_reg==0 cannot occur in RUN. The timer never wraps.
            end
         end
      end
   end

   assign count = count_reg;
   assign busy  = busy_reg;
   assign done  = done_reg;

endmodule

// File: tb/tb_down_counter_timer.sv
// -----------------------------------------------------------------------------
// tb_down_counter_timer
//
// Two instances share one set of inputs: u0 uses PRESCALE=1 and u1 uses
// PRESCALE=4. A reference model counts the enabled cycles elapsed since the
// last load. From that it derives the remaining count as
// N - floor(t/PRESCALE) and detects expiry at t == N*PRESCALE. A compare
// process checks both instances on every falling edge. Directed sequences
// with literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_down_counter_timer;

   logic       clock;
   logic       reset;
   logic       start;
   logic [7:0] load_value;
   logic       enable;
   logic       auto_reload;
   logic       abort;
   logic [7:0] count0, count1;
   logic       busy0, busy1, done0, done1;

   int n_checks = 0;
   int n_pass   = 0;

   down_counter_timer #(.WIDTH(8), .PRESCALE(1)) u0 (
      .clock(clock), .reset(reset), .start(start), .load_value(load_value),
      .enable(enable), .auto_reload(auto_reload), .abort(abort),
      .count(count0), .busy(busy0), .done(done0));

   down_counter_timer #(.WIDTH(8), .PRESCALE(4)) u1 (
      .clock(clock), .reset(reset), .start(start), .load_value(load_value),
      .enable(enable), .auto_reload(auto_reload), .abort(abort),
      .count(count1), .busy(busy1), .done(done1));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic int ps(input int i);
      return (i == 0) ? 1 : 4;
   endfunction

   // ---------------- reference model ----------------
   bit m_run[2];
   int m_n[2];
   int m_t[2];
   int m_count[2];
   bit m_done[2];

   always @(posedge clock or negedge reset) begin : model
      int  t, n, cnt;
      bit  run, dn;
      for (int i = 0; i < 2; i++) begin
         if (!reset) begin
            m_run[i] <= 1'b0; m_n[i] <= 0; m_t[i] <= 0;
            m_count[i] <= 0;  m_done[i] <= 1'b0;
         end else begin
            run = m_run[i]; n = m_n[i]; t = m_t[i]; cnt = m_count[i]; dn = 1'b0;
            if (abort) begin
               run = 1'b0; cnt = 0; t = 0;
            end else if (start) begin
               t = 0;
               if (load_value != 0) begin
                  run = 1'b1; n = int'(load_value); cnt = n;
               end else begin
                  run = 1'b0; cnt = 0; dn = 1'b1;
               end
            end else if (run && enable) begin
               t = t + 1;
               if (t == n * ps(i)) begin
                  dn = 1'b1;
                  t  = 0;
                  if (auto_reload) cnt = n;
                  else begin run = 1'b0; cnt = 0; end
               end else begin
                  cnt = n - t / ps(i);
               end
            end
            m_run[i] <= run; m_n[i] <= n; m_t[i] <= t;
            m_count[i] <= cnt; m_done[i] <= dn;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clock) begin
      if (reset) begin
         check("u0_count", 32'(count0), 32'(m_count[0]));
         check("u0_busy",  32'(busy0),  32'(m_run[0]));
         check("u0_done",  32'(done0),  32'(m_done[0]));
         check("u1_count", 32'(count1), 32'(m_count[1]));
         check("u1_busy",  32'(busy1),  32'(m_run[1]));
         check("u1_done",  32'(done1),  32'(m_done[1]));
      end
   end

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic clear();
      abort = 1'b1; start = 1'b0; tick(); abort = 1'b0;
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; load_value = '0; enable = 1'b0;
      auto_reload = 1'b0; abort = 1'b0;
      repeat (2) tick();
      check("reset_count", 32'(count0), 0);
      check("reset_busy",  32'(busy0), 0);
      check("reset_done",  32'(done0), 0);
      reset = 1'b1;
      tick();

      // One-shot, N=5, PRESCALE=1
      start = 1'b1; load_value = 8'd5; enable = 1'b1; auto_reload = 1'b0;
      tick(); start = 1'b0;
      check("os_load", 32'(count0), 5);
      check("os_busy", 32'(busy0), 1);
      for (int k = 4; k >= 1; k--) begin
         tick();
         check("os_step", 32'(count0), 32'(k));
         check("os_nodone", 32'(done0), 0);
      end
      tick();
      check("os_end_count", 32'(count0), 0);
      check("os_end_done", 32'(done0), 1);
      check("os_end_busy", 32'(busy0), 0);
      tick();
      check("os_pulse_once", 32'(done0), 0);
      clear();

      // Auto-reload, N=3
      auto_reload = 1'b1; start = 1'b1; load_value = 8'd3;
      tick(); start = 1'b0;
      check("ar_load", 32'(count0), 3);
      for (int k = 1; k <= 9; k++) begin
         tick();
         check("ar_count", 32'(count0), 32'(3 - (k % 3)));
         check("ar_done", 32'(done0), (k % 3 == 0) ? 1 : 0);
         check("ar_busy", 32'(busy0), 1);
      end
      clear(); auto_reload = 1'b0;

      // PRESCALE=4 (u1), N=2, enable alternating
      start = 1'b1; load_value = 8'd2;
      tick(); start = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         enable = (k % 2 == 1);
         tick();
         if (k == 6)  check("ps_hold", 32'(count1), 2);
         if (k == 7)  check("ps_dec", 32'(count1), 1);
         if (k == 14) check("ps_nodone", 32'(done1), 0);
         if (k == 15) begin
            check("ps_done", 32'(done1), 1);
            check("ps_busy", 32'(busy1), 0);
         end
      end
      clear(); enable = 1'b1;

      // Abort beats start, then a zero-length start
      start = 1'b1; load_value = 8'd10; tick(); start = 1'b0;
      repeat (4) tick();
      check("ab_at6", 32'(count0), 6);
      abort = 1'b1; start = 1'b1; load_value = 8'd9; tick();
      abort = 1'b0;
      check("ab_count", 32'(count0), 0);
      check("ab_busy", 32'(busy0), 0);
      check("ab_done", 32'(done0), 0);
      load_value = 8'd0; tick(); start = 1'b0;
      check("zero_done", 32'(done0), 1);
      check("zero_busy", 32'(busy0), 0);
      check("zero_count", 32'(count0), 0);
      tick();
      check("zero_once", 32'(done0), 0);

      // Restart while running
      start = 1'b1; load_value = 8'd10; tick(); start = 1'b0;
      repeat (6) tick();
      check("rs_at4", 32'(count0), 4);
      start = 1'b1; load_value = 8'd7; tick(); start = 1'b0;
      check("rs_load", 32'(count0), 7);
      repeat (6) tick();
      check("rs_before", 32'(done0), 0);
      tick();
      check("rs_done", 32'(done0), 1);
      check("rs_count", 32'(count0), 0);

      // Asynchronous reset in mid-cycle
      start = 1'b1; load_value = 8'd8; tick(); start = 1'b0;
      repeat (5) tick();
      check("rst_at3", 32'(count0), 3);
      #2 reset = 1'b0;
      #1;
      check("rst_async_count", 32'(count0), 0);
      check("rst_async_busy", 32'(busy0), 0);
      check("rst_async_done", 32'(done0), 0);
      check("rst_async_count1", 32'(count1), 0);
      tick(); reset = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         check("rst_no_done", 32'(done0), 0);
      end

      // Randomized stimulus against the model
      for (int k = 0; k < 4000; k++) begin
         start       = ($urandom_range(0, 99) < 6);
         abort       = ($urandom_range(0, 99) < 2);
         enable      = ($urandom_range(0, 99) < 70);
         auto_reload = ($urandom_range(0, 99) < 50);
         load_value  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
         reset       = ($urandom_range(0, 999) >= 3);
         tick();
      end
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable down-counting timer: the count-down counterpart to the team's free-running up counter.
- Loads a start value, decrements on enabled (optionally prescaled) clock ticks, and pulses `done` when it reaches zero.
- Supports one-shot and auto-reload operation, and abort.
- Used as a timeout/interval generator by control FSMs in the same design.

Parameters:
- WIDTH, 8, bit width of `load_value` and `count`.
- PRESCALE, 1, number of enabled cycles per decrement; legal range ≥1.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately, independent of `clock`.
- start  input  1  load `load_value` and begin counting.
- load_value  input  WIDTH  initial / reload count, sampled when `start`=1.
- enable  input  1  tick qualifier; counting and prescaler advance only when 1.
- auto_reload  input  1  1: reload on expiry and keep running; 0: one-shot.
- abort  input  1  stop counting and return to IDLE without `done`.
- count  output  WIDTH  current remaining count (registered).
- busy  output  1  1 while in RUN state (registered).
- done  output  1  one-cycle pulse on expiry (registered).

Behaviour:
- Reset (`reset`=0, asynchronous):
  - `count`=0, `busy`=0, `done`=0, state=IDLE.
  - Internal reload register=0, prescaler=0.
  - Reset asserted mid-count discards all progress; no `done` is produced.
- States: IDLE, RUN. `busy` = (state==RUN).
- `done` defaults to 0 every cycle; it is set for exactly one cycle only by the events below.
- Priority at each edge: `abort` > `start` > decrement.
- IDLE:
  - `start`=1 with `load_value`≠0: `count`←`load_value`, reload register←`load_value`, prescaler←0, state←RUN.
  - `start`=1 with `load_value`=0: `done`←1 on the next cycle, state stays IDLE, `count` stays 0 (zero-length timer).
  - `enable` and `auto_reload` are ignored in IDLE.
- RUN:
  - `abort`=1: state←IDLE, `count`←0, prescaler←0, `done` stays 0.
  - `start`=1 (restart): same as the IDLE start. A `load_value` of 0 produces `done`, IDLE, `count`=0.
  - `enable`=1 with prescaler≠PRESCALE-1: prescaler increments by 1.
  - `enable`=1 with prescaler=PRESCALE-1: prescaler←0 and a decrement occurs.
  - `enable`=0: `count` and prescaler hold.
- Decrement:
  - If `count`>1: `count`←`count`-1.
  - If `count`=1 (expiry): `done`←1.
    - `auto_reload`=1, sampled at the expiry edge: `count`←reload register, stay RUN.
    - `auto_reload`=0: `count`←0, state←IDLE.
- Arithmetic: unsigned, WIDTH bits. `count` never decrements from 0 and never wraps.
- Latency (PRESCALE=1, `enable` held 1):
  - Start with N at edge E0; `count`=N after E0.
  - `done` is high for the cycle after edge E0+N; `busy` drops on that same edge (one-shot).
  - In general, `done` follows N·PRESCALE enabled cycles after start.
- Auto-reload period: N·PRESCALE enabled cycles between `done` pulses, with no gap cycle.
- `load_value` is sampled only on `start`; changes at other times have no effect.

Test Plan:
- Reset, then start with `load_value`=5, `enable`=1, PRESCALE=1, `auto_reload`=0 → `count` steps 5,4,3,2,1,0 on successive cycles; `done`=1 for one cycle as `count` becomes 0; `busy` 1→0 on the same edge.
- Same as above with `auto_reload`=1, `load_value`=3 → `count` 3,2,1,3,2,1,…; `done` pulses every 3 cycles; `busy` stays 1.
- PRESCALE=4, `load_value`=2, `enable` toggled 1,0,1,0… → `count` decrements once per 4 enabled cycles, i.e. every 8 clocks; `done` after 16 clocks; holds during `enable`=0.
- Start with 10, then at `count`=6 assert `abort` and `start` together → `abort` wins: IDLE, `count`=0, no `done`. Then start with 0 → single `done` pulse, `busy` stays 0.
- Start with 10; at `count`=4 assert `start` with `load_value`=7 → `count`=7 next cycle, prescaler cleared; `done` 7 cycles later.
- Start with 8; drive `reset`=0 asynchronously mid-cycle at `count`=3 → outputs go to 0 immediately, before the next clock edge; after release, no `done` until a new `start`.
